secure_memory_slave: RTL
========================

Name: secure_memory_slave

Overview:
- Avalon-MM slave responder: the memory-side end of the secure memory master interface (address/byteenable/chipselect/write/writedata/readdata/waitrequest).
- Stores every word XOR-scrambled with a fixed key and returns descrambled data on reads, so the raw array never holds plaintext.
- Sits on the Avalon fabric behind the secure memory custom instruction's master port.
- Scrubs the whole array after reset so that unwritten locations read as zero.

Parameters:
- XOR_KEY, 32'h95DA4EAB, scramble key applied on write and on read.
- ADDR_WIDTH, 8, word-address width; array depth is 2**ADDR_WIDTH words of 32 bits.
- WAIT_CYCLES, 1, wait states inserted before acknowledge; legal range 1..15.

Ports:
- clk  in  1  single clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- chipselect  in  1  transfer request qualifier.
- read  in  1  read request.
- write  in  1  write request.
- address  in  ADDR_WIDTH  word address.
- byteenable  in  4  per-byte write enable; ignored on reads.
- writedata  in  32  plaintext write data.
- readdata  out  32  plaintext read data, registered.
- waitrequest  out  1  high = slave not ready; a transfer completes in the cycle chipselect && !waitrequest.
- err_illegal  out  1  sticky flag: a request had read and write both asserted.
- scrub_busy  out  1  high while the post-reset scrub runs.

Behaviour:
- Reset values: state=SCRUB, scrub counter=0, readdata=0, err_illegal=0, waitrequest=1, scrub_busy=1. Array contents are not reset directly; the scrub overwrites them.
- Storage rule:
  - Write: mem[a][byte i] <= (writedata ^ XOR_KEY)[byte i] for each i with byteenable[i]=1; other bytes are unchanged.
  - Read: readdata <= mem[a] ^ XOR_KEY.
- waitrequest = 1 in every state except ACK. It is a decode of registered state, with no combinational path from the inputs.
- FSM:
  - SCRUB: writes XOR_KEY (scrambled zero) to mem[cnt] and increments cnt each cycle. After cnt reaches 2**ADDR_WIDTH-1, go to IDLE. Takes 2**ADDR_WIDTH cycles. Requests arriving during SCRUB are held off by waitrequest and are not latched.
  - IDLE: if chipselect && (read || write), latch address, byteenable, writedata and op; load wait counter = WAIT_CYCLES-1; go to WAIT. Otherwise stay in IDLE.
  - WAIT: decrement the counter. When it is 0, commit: perform the write into the array, or register readdata; then go to ACK.
  - ACK: waitrequest=0 for exactly one cycle, then return to IDLE unconditionally.
- Latency: request sampled in IDLE at cycle t; waitrequest low in cycle t+WAIT_CYCLES+1. Back-to-back requests: the next request is sampled in IDLE no earlier than cycle t+WAIT_CYCLES+2.
- Illegal op (read && write both high when sampled):
  - no array write;
  - readdata <= 32'h0;
  - err_illegal <= 1 at commit; it clears only on reset;
  - still acknowledged through WAIT and ACK.
- Inputs change or chipselect drops during WAIT: ignored. The transaction completes using the values latched in IDLE.
- readdata holds its last value through writes and idle cycles; it updates only on a read or illegal commit.
- Reset asserted mid-operation: immediate abort. A pending write is not committed; the FSM re-enters SCRUB, so all words read 0 afterwards.
- No address range error: every ADDR_WIDTH value is a valid location.

Test Plan:
- Post-reset scrub (ADDR_WIDTH=4): release reset -> scrub_busy and waitrequest high for exactly 16 cycles. Reads of addresses 0..15 then return 32'h00000000, and raw mem[5] == 32'h95DA4EAB.
- Write/read (WAIT_CYCLES=1): write 32'h12345678 to address 3 -> raw mem[3] == 32'h87EE18D3. Read of address 3 returns 32'h12345678, with waitrequest low in cycle t+2 only.
- Byte enables: after the previous write, write 32'hAAAABBBB with byteenable 4'b0011 to address 3 -> read returns 32'h1234BBBB.
- Illegal request: read=write=1 to address 3 with writedata 32'hFFFFFFFF -> readdata 32'h0, err_illegal=1 and stays 1. Subsequent read of address 3 still returns 32'h1234BBBB.
- Wait states (WAIT_CYCLES=3): request sampled at t -> waitrequest low only in cycle t+4. Toggling address and writedata during WAIT has no effect on the committed location or data.
- Reset mid-write: assert reset during WAIT of a write of 32'hDEADBEEF to address 7 -> after release and scrub, address 7 reads 32'h0 and err_illegal=0.

Source files
------------

// File: rtl/secure_memory_slave.sv
// secure_memory_slave
//   Avalon-MM slave backing store for the secure memory master. Every word is
//   held XOR-scrambled with XOR_KEY; reads return descrambled data. After
//   reset the whole array is scrubbed to scrambled zero before any request is
//   accepted.
// Ports:
//   clk, reset (async, active-low)
//   chipselect/read/write/address/byteenable/writedata : request
//   readdata    : registered plaintext read data
//   waitrequest : low for exactly one cycle when a transfer completes
//   err_illegal : sticky, set when a request had read and write both high
//   scrub_busy  : high while the post-reset scrub runs
module secure_memory_slave #(
  parameter logic [31:0] XOR_KEY     = 32'h95DA4EAB,
  parameter int          ADDR_WIDTH  = 8,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [3:0]            byteenable,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  waitrequest,
  output logic                  err_illegal,
  output logic                  scrub_busy
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_SCRUB,
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  op_rd_q, op_rd_d;
  logic                  op_wr_q, op_wr_d;
  logic [31:0]           readdata_q, readdata_d;
  logic                  err_q, err_d;

  logic [31:0]           mem_q [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_data;
  logic [3:0]            mem_be;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    op_rd_d    = op_rd_q;
    op_wr_d    = op_wr_q;
    readdata_d = readdata_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    mem_addr   = addr_q;
    mem_data   = wdata_q ^ XOR_KEY;
    mem_be     = be_q;

    unique case (state_q)
      S_SCRUB: begin
        // Scrambled zero, so unwritten locations descramble to 0.
        mem_we   = 1'b1;
        mem_addr = cnt_q;
        mem_data = XOR_KEY;
        mem_be   = '1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (chipselect && (read || write)) begin
          addr_d  = address;
          be_d    = byteenable;
          wdata_d = writedata;
          op_rd_d = read;
          op_wr_d = write;
          wcnt_d  = WAIT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wcnt_q == '0) begin
          if (op_rd_q && op_wr_q) begin
            readdata_d = '0;
            err_d      = 1'b1;
          end else if (op_wr_q) begin
            mem_we = 1'b1;
          end else begin
            readdata_d = mem_q[addr_q] ^ XOR_KEY;
          end
          state_d = S_ACK;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      S_ACK: state_d = S_IDLE;
      default: state_d = S_SCRUB;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_SCRUB;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      op_rd_q    <= 1'b0;
      op_wr_q    <= 1'b0;
      readdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      op_rd_q    <= op_rd_d;
      op_wr_q    <= op_wr_d;
      readdata_q <= readdata_d;
      err_q      <= err_d;
    end
  end

  // Array has no reset; the scrub pass initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (mem_be[i]) mem_q[mem_addr][8*i +: 8] <= mem_data[8*i +: 8];
      end
    end
  end

  assign readdata    = readdata_q;
  assign err_illegal = err_q;
  assign waitrequest = (state_q != S_ACK);
  assign scrub_busy  = (state_q == S_SCRUB);

endmodule
